// File: rtl/feg_pkg.sv
// Shared definitions for the FEG 8-bit core: ALU opcodes, PC-stage state type,
// and the default branch-target table.
package feg_pkg;

    localparam int PC_W_DEF      = 10;
    localparam int LUT_IDX_W_DEF = 4;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_CMP = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_SHF = 3'b110;
    localparam logic [2:0] OP_BR  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    // Entries are absolute addresses, or two's-complement offsets in relative
    // builds (1020 = -4, 1008 = -16, 1010 = -14).
    function automatic logic [PC_W_DEF-1:0] lut_default(input logic [LUT_IDX_W_DEF-1:0] idx);
        logic [PC_W_DEF-1:0] entry;
        case (idx)
            4'd0:    entry = 10'd12;
            4'd1:    entry = 10'd24;
            4'd2:    entry = 10'd40;
            4'd3:    entry = 10'd1020;
            4'd4:    entry = 10'd100;
            4'd5:    entry = 10'd200;
            4'd6:    entry = 10'd300;
            4'd7:    entry = 10'd512;
            4'd8:    entry = 10'd1008;
            4'd9:    entry = 10'd8;
            4'd10:   entry = 10'd700;
            4'd11:   entry = 10'd900;
            4'd12:   entry = 10'd1000;
            4'd13:   entry = 10'd5;
            4'd14:   entry = 10'd1010;
            default: entry = 10'd1023;
        endcase
        return entry;
    endfunction

endpackage

// File: rtl/br_lut.sv
// Branch-target lookup: combinational map from instruction LUT index to a
// PC-wide table entry (absolute address or signed offset, depending on build).
module br_lut
    import feg_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int LUT_IDX_W = LUT_IDX_W_DEF
) (
    input  logic [LUT_IDX_W-1:0] lut_idx,
    output logic [PC_W-1:0]      entry
);

    logic [LUT_IDX_W_DEF-1:0] idx_n;
    logic [PC_W_DEF-1:0]      raw;

    assign idx_n = LUT_IDX_W_DEF'(lut_idx);
    assign raw   = lut_default(idx_n);
    assign entry = PC_W'(raw);

endmodule

// File: rtl/prog_ctr_br.sv
// Program counter and branch stage for the FEG core: run/halt FSM, PC register,
// carry and compare flags. Define BR_RELATIVE_EN for PC-relative branch targets.
module prog_ctr_br
    import feg_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int LUT_IDX_W  = LUT_IDX_W_DEF,
    parameter int START_ADDR = 0,
    parameter int HALT_ADDR  = 1023
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 stall,
    input  logic [2:0]           alu_cmd,
    input  logic                 br_logic,
    input  logic                 sc_o,
    input  logic                 sc_we,
    input  logic [LUT_IDX_W-1:0] lut_idx,
    output logic [PC_W-1:0]      pc,
    output logic                 sc_q,
    output logic                 br_flag_q,
    output logic                 done
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0] HALT_PC  = PC_W'(HALT_ADDR);

    pc_state_t         state, state_nxt;
    logic              start_q;
    logic              start_rise, start_fall;
    logic [PC_W-1:0]   pc_nxt;
    logic              sc_nxt, br_nxt;
    logic [PC_W-1:0]   lut_entry;
    logic [PC_W-1:0]   br_target;
    logic [PC_W:0]     pc_inc;
    logic              br_taken;

    br_lut #(
        .PC_W      (PC_W),
        .LUT_IDX_W (LUT_IDX_W)
    ) u_br_lut (
        .lut_idx (lut_idx),
        .entry   (lut_entry)
    );

    assign start_rise = start & ~start_q;
    assign start_fall = ~start & start_q;
    assign pc_inc     = {1'b0, pc} + (PC_W+1)'(1);
    // Decision uses the registered flag, so a CMP must precede its BR.
    assign br_taken   = (alu_cmd == OP_BR) && br_flag_q;

`ifdef BR_RELATIVE_EN
    assign br_target = pc + lut_entry;
`else
    assign br_target = lut_entry;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        sc_nxt    = sc_q;
        br_nxt    = br_flag_q;
        case (state)
            IDLE: begin
                pc_nxt = START_PC;
                sc_nxt = 1'b0;
                br_nxt = 1'b0;
                if (start_fall) state_nxt = RUN;
            end
            RUN: begin
                if (start) begin
                    state_nxt = IDLE;
                    pc_nxt    = START_PC;
                    sc_nxt    = 1'b0;
                    br_nxt    = 1'b0;
                end else if (pc == HALT_PC) begin
                    state_nxt = HALT;
                end else if (!stall) begin
                    if (br_taken) begin
                        pc_nxt = br_target;
                        br_nxt = 1'b0;
                    end else begin
                        if (alu_cmd == OP_CMP) br_nxt = br_logic;
                        // Falling off the end of instruction memory halts with pc held.
                        if (pc_inc[PC_W]) state_nxt = HALT;
                        else              pc_nxt    = pc_inc[PC_W-1:0];
                    end
                    if (sc_we) sc_nxt = sc_o;
                end
            end
            HALT: begin
                if (start_rise) begin
                    state_nxt = IDLE;
                    pc_nxt    = START_PC;
                    sc_nxt    = 1'b0;
                    br_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                pc_nxt    = START_PC;
                sc_nxt    = 1'b0;
                br_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            pc        <= START_PC;
            sc_q      <= 1'b0;
            br_flag_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            sc_q      <= sc_nxt;
            br_flag_q <= br_nxt;
            start_q   <= start;
        end
    end

    assign done = (state == HALT);

endmodule
